detect_rr_scheduler: RTL and testbench

//  Shares one serial-pattern event output among N_CH serial input channels.
//  - Each channel runs a "0 then 1" sequence detector.
//  - Each hit raises a per-channel pending flag.
//  - A round-robin scheduler grants the shared y_out pulse (HOLD cycles wide,

---
 rtl/detect_rr_scheduler_pkg.sv | 30 +++
 rtl/detect_rr_scheduler_seq_edge_detector.sv | 31 +++
 rtl/detect_rr_scheduler.sv | 153 +++++++++++++++
 tb/tb_detect_rr_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin "0 then 1" event scheduler.
package detect_rr_scheduler_pkg;

  // Scheduler phases: waiting for work, driving the pulse, enforcing idle spacing.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } sched_state_t;

  // Per-channel detector: ARMED means the last enabled sample was a 0.
  typedef enum logic {
    D_IDLE  = 1'b0,
    D_ARMED = 1'b1
  } det_state_t;

  // Ceiling log2, never below 1 so derived vectors always have a legal width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/detect_rr_scheduler_seq_edge_detector.sv
// Single-channel "0 then 1" detector. The hit is a combinational qualifier of
// the current sample so the parent can capture it into pending on the same edge.
module detect_rr_scheduler_seq_edge_detector
  import detect_rr_scheduler_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic x_i,
  output logic hit_o
);

  det_state_t state_q;

  // A 1 arriving while armed completes the pattern; disabled channels never hit.
  assign hit_o = en_i && (state_q == D_ARMED) && x_i;

  // Arm on any enabled 0, drop back to idle on a 1 or when disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= D_IDLE;
    end else if (!en_i) begin
      state_q <= D_IDLE;
    end else if (!x_i) begin
      state_q <= D_ARMED;
    end else begin
      state_q <= D_IDLE;
    end
  end

endmodule

// File: rtl/detect_rr_scheduler.sv
// N_CH serial detectors feeding per-channel pending flags; a round-robin
// scheduler hands the single y_o pulse (HOLD wide, then GAP idle) to one
// pending channel at a time and reports which one on y_id_o.
module detect_rr_scheduler
  import detect_rr_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int HOLD = 2,
  parameter int GAP  = 2,
  parameter int IDW  = clog2(N_CH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] x_i,
  input  logic [N_CH-1:0] enable_i,
  input  logic            ovf_clr_i,
  output logic            y_o,
  output logic [IDW-1:0]  y_id_o,
  output logic [N_CH-1:0] pending_o,
  output logic [N_CH-1:0] overflow_o
);

  localparam int CW = clog2(((HOLD > GAP) ? HOLD : GAP) + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDW:0]  NCH_W     = (IDW + 1)'(N_CH);

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] overflow_q, overflow_d;
  logic [N_CH-1:0] grant_vec;
  logic [IDW-1:0]  winner;
  logic            winner_found;
  logic            grant_now;

  sched_state_t    state_q;
  logic [CW-1:0]   cnt_q;
  logic [IDW-1:0]  last_grant_q;
  logic            y_q;
  logic [IDW-1:0]  y_id_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_det
      detect_rr_scheduler_seq_edge_detector u_det (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (enable_i[gi]),
        .x_i    (x_i[gi]),
        .hit_o  (hit[gi])
      );
    end
  endgenerate

  // Rotating priority search: first pending channel after the last winner, with wrap.
  always_comb begin
    logic [IDW:0] idx;
    winner       = '0;
    winner_found = 1'b0;
    idx          = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = {1'b0, last_grant_q} + (IDW + 1)'(k);
      if (idx >= NCH_W) begin
        idx = idx - NCH_W;
      end
      if (!winner_found && pending_q[idx[IDW-1:0]]) begin
        winner_found = 1'b1;
        winner       = idx[IDW-1:0];
      end
    end
  end

  assign grant_now = (state_q == S_IDLE) && winner_found;

  // One-hot clear mask for the channel being granted on this edge.
  always_comb begin
    grant_vec = '0;
    if (grant_now) begin
      grant_vec[winner] = 1'b1;
    end
  end

  // A same-edge hit re-sets pending after the grant clears it; overflow only when
  // a hit lands on an already-pending channel that is not being served now.
  always_comb begin
    pending_d  = (pending_q & ~grant_vec) | hit;
    overflow_d = (ovf_clr_i ? '0 : overflow_q) | (hit & pending_q & ~grant_vec);
  end

  // Pending and sticky overflow flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Scheduler FSM with registered pulse outputs; the counter restarts on each phase entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDW'(N_CH - 1);
      y_q          <= 1'b0;
      y_id_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_now) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            last_grant_q <= winner;
            y_q          <= 1'b1;
            y_id_q       <= winner;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= (GAP > 0) ? S_GAP : S_IDLE;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            y_id_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          y_q     <= 1'b0;
          y_id_q  <= '0;
        end
      endcase
    end
  end

  assign y_o        = y_q;
  assign y_id_o     = y_id_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_detect_rr_scheduler.sv
// Bench for detect_rr_scheduler: two instances (HOLD=2/GAP=2 and HOLD=1/GAP=0)
// share the same stimulus and are compared against a timestamp-based model.
module tb_detect_rr_scheduler;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] en;
  logic       clr;

  logic       ya, yb;
  logic [1:0] ida, idb;
  logic [3:0] pa, pb, oa, ob;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  detect_rr_scheduler #(.N_CH(4), .HOLD(2), .GAP(2), .IDW(2)) dut_a (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .x_i        (x),
    .enable_i   (en),
    .ovf_clr_i  (clr),
    .y_o        (ya),
    .y_id_o     (ida),
    .pending_o  (pa),
    .overflow_o (oa)
  );

  detect_rr_scheduler #(.N_CH(4), .HOLD(1), .GAP(0), .IDW(2)) dut_b (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .x_i        (x),
    .enable_i   (en),
    .ovf_clr_i  (clr),
    .y_o        (yb),
    .y_id_o     (idb),
    .pending_o  (pb),
    .overflow_o (ob)
  );

  // Reference model: detectors remember "last enabled sample was 0"; the
  // scheduler is described by the cycle a pulse ends and the first cycle a new
  // grant is allowed.
  int         hold_k [2] = '{2, 1};
  int         gap_k  [2] = '{2, 0};
  logic [3:0] m_armed;
  logic [3:0] m_pend [2];
  logic [3:0] m_ovf  [2];
  int         m_last [2];
  logic       m_y    [2];
  int         m_id   [2];
  int         m_free [2];
  int         m_off  [2];
  int         cyc = 0;

  task automatic model_reset();
    m_armed = '0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0;
      m_ovf[k]  = '0;
      m_last[k] = N - 1;
      m_y[k]    = 1'b0;
      m_id[k]   = 0;
      m_free[k] = 0;
      m_off[k]  = -1;
    end
  endtask

  task automatic model_edge();
    logic [3:0] hits;
    logic [3:0] gmask;
    int         w;
    bit         found;
    hits    = en & m_armed & x;
    m_armed = en & ~x;
    for (int k = 0; k < 2; k++) begin
      gmask = '0;
      if (cyc >= m_free[k] && m_pend[k] != 0) begin
        found = 0;
        w     = 0;
        for (int j = 1; j <= N; j++) begin
          if (!found && m_pend[k][(m_last[k] + j) % N]) begin
            found = 1;
            w     = (m_last[k] + j) % N;
          end
        end
        gmask[w]  = 1'b1;
        m_last[k] = w;
        m_y[k]    = 1'b1;
        m_id[k]   = w;
        m_off[k]  = cyc + hold_k[k];
        m_free[k] = cyc + hold_k[k] + gap_k[k] + 1;
      end else if (cyc == m_off[k]) begin
        m_y[k]  = 1'b0;
        m_id[k] = 0;
      end
      m_ovf[k]  = (clr ? 4'b0 : m_ovf[k]) | (hits & m_pend[k] & ~gmask);
      m_pend[k] = (m_pend[k] & ~gmask) | hits;
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.y",        32'(ya),  32'(m_y[0]));
    chk("a.y_id",     32'(ida), 32'(m_id[0]));
    chk("a.pending",  32'(pa),  32'(m_pend[0]));
    chk("a.overflow", 32'(oa),  32'(m_ovf[0]));
    chk("b.y",        32'(yb),  32'(m_y[1]));
    chk("b.y_id",     32'(idb), 32'(m_id[1]));
    chk("b.pending",  32'(pb),  32'(m_pend[1]));
    chk("b.overflow", 32'(ob),  32'(m_ovf[1]));
  endtask

  task automatic step(input logic [3:0] xv, input logic [3:0] ev, input logic c);
    @(negedge clk);
    x   = xv;
    en  = ev;
    clr = c;
    @(posedge clk);
    model_edge();
    #1;
    $display("cyc=%0d x=%b en=%b clr=%b | a: y=%b id=%0d p=%b o=%b | b: y=%b id=%0d p=%b o=%b",
             cyc, x, en, clr, ya, ida, pa, oa, yb, idb, pb, ob);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b1111, 4'b1111, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    x     = 4'b1111;
    en    = 4'b1111;
    clr   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_all();
    chk("reset.y", 32'(ya), 32'd0);
    rst_n = 1'b1;

    // Single hit on channel 0: pulse id 0 for HOLD cycles, then GAP idle.
    step(4'b1110, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    chk("t1.pend0", 32'(pa[0]), 32'd1);
    step(4'b1111, 4'b1111, 1'b0);
    chk("t1.y_rise", 32'(ya), 32'd1);
    chk("t1.y_id", 32'(ida), 32'd0);
    idle(8);

    // Channels 1 and 3 together after channel 0 was last: 1 first, 3 five edges later.
    step(4'b0101, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    chk("t2.first", 32'(ida), 32'd1);
    idle(4);
    step(4'b1111, 4'b1111, 1'b0);
    chk("t2.second_y", 32'(ya), 32'd1);
    chk("t2.second", 32'(ida), 32'd3);
    idle(8);

    // Channel 2 hits twice while channel 0 is served: overflow, then clear.
    step(4'b1010, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    step(4'b1011, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    chk("t3.ovf2", 32'(oa[2]), 32'd1);
    idle(10);
    step(4'b1111, 4'b1111, 1'b1);
    chk("t3.ovf_clr", 32'(oa), 32'd0);
    idle(2);

    // Disabled channel 1 toggling never hits; after re-enable it does.
    for (int i = 0; i < 3; i++) begin
      step(4'b1101, 4'b1101, 1'b0);
      step(4'b1111, 4'b1101, 1'b0);
      chk("t4.no_pend", 32'(pa[1]), 32'd0);
      chk("t4.no_pulse", 32'(ya), 32'd0);
    end
    step(4'b1101, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    chk("t4.y", 32'(ya), 32'd1);
    chk("t4.y_id", 32'(ida), 32'd1);
    idle(8);

    // Reset while holding a pulse with another channel still pending.
    step(4'b1100, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    chk("t5.in_hold", 32'(ya), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5.y_killed", 32'(ya), 32'd0);
    chk("t5.pend_a", 32'(pa), 32'd0);
    chk("t5.pend_b", 32'(pb), 32'd0);
    model_reset();
    check_all();
    rst_n = 1'b1;

    // All four pending: B (HOLD=1, GAP=0) pulses 0,1,2,3 on alternate cycles.
    step(4'b0000, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(4'b1111, 4'b1111, 1'b0);
      chk("t6.b_y", 32'(yb), 32'd1);
      chk("t6.b_id", 32'(idb), 32'(j));
      if (j == 0) chk("t5.first_a", 32'(ida), 32'd0);
      step(4'b1111, 4'b1111, 1'b0);
      chk("t6.b_gap", 32'(yb), 32'd0);
    end
    idle(12);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] xv, ev;
      logic       c;
      xv = 4'($urandom);
      ev = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1111;
      c  = ($urandom_range(0, 15) == 0);
      step(xv, ev, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
